decode_stage_p: RTL and testbench
=================================

DECODE_STAGE_P -- requirements
Module: decode_stage_p

Interface
REQ-001 Parameter DATA_W, default 16: register, operand and immediate width; legal range 8..32.
REQ-002 Parameter IMM_SIGNED, default 0: 0 zero-extends instr[7:0], 1 sign-extends instr[7:0], to DATA_W.
REQ-003 Parameter HAZ_EN, default 1: 1 enables load-use stall detection; 0 removes it.
REQ-004 Port clk, input, 1: single clock; all state changes on its rising edge.
REQ-005 Port reset, input, 1: synchronous, active-high reset.
REQ-006 Port instruction, input, 16: opcode [15:13], rd/rs1 [12:10], rs2 [9:7], imm [7:0].
REQ-007 Port in_valid, input, 1: instruction is valid this cycle.
REQ-008 Port in_ready, output, 1: stage accepts instruction this cycle.
REQ-009 Ports write_en (1), write_addr (3), write_data (DATA_W), inputs: writeback port.
REQ-010 Port flush, input, 1: discard the held and the incoming instruction.
REQ-011 Port out_ready, input, 1: execute stage accepts the output bundle.
REQ-012 Port out_valid, output, 1: output bundle valid.
REQ-013 Ports read_data1_buf, read_data2_buf, immediate_buf, outputs, DATA_W: registered operands.
REQ-014 Ports alu_operation_buf (3), mem_read_buf, mem_write_buf, wb_buf, destination_alu_select_buf (1 each), dest_addr_buf (3), outputs: registered control.

Function
REQ-015 Decode: 000 NOP (all controls 0, alu 000); 001 ADD, 010 SUB, 011 AND, 100 OR: alu op = opcode, wb=1; 101 LDI: wb=1, destination_alu_select=1, alu 000; 110 LD: mem_read=1, wb=1, alu 001 (address = rs2 + imm); 111 ST: mem_write=1, alu 001.
REQ-016 dest_addr = instr[12:10]; read port 1 addresses instr[12:10], port 2 addresses instr[9:7].
REQ-017 Register file: 8 x DATA_W; all 8 registers writable (R0 not hardwired); write on clk when write_en.
REQ-018 Same-cycle write/read of one address: read returns write_data (write-through bypass), on both ports independently.
REQ-019 Output register (ID/EX) loads when in_valid && in_ready; out_valid set on load, cleared when out_ready && !load.
REQ-020 in_ready = !out_valid || out_ready, gated low by a load-use stall.
REQ-021 Load-use stall (HAZ_EN=1): out_valid && mem_read_buf && dest_addr_buf equals rs1 (opcodes 001-100, 111) or rs2 (opcodes 001-100, 110, 111) -> in_ready=0; when out_ready, out_valid drops next cycle (bubble) and the instruction is accepted the cycle after.
REQ-022 Stall holds every output register unchanged; no control signal changes while out_valid && !out_ready.
REQ-023 Latency: accepted instruction appears on outputs exactly 1 cycle later; throughput 1/cycle without stalls.
REQ-024 flush: out_valid=0 next cycle, incoming instruction dropped, in_ready forced 0 that cycle; flush beats load and stall.
REQ-025 NOP with in_valid is accepted and produces out_valid=1 with all controls 0.
REQ-026 Writeback is independent of in_valid/stall/flush; it always updates the file.

Reset
REQ-027 reset: all 8 registers, all *_buf outputs, dest_addr_buf and out_valid -> 0 on the next edge.
REQ-028 Reset beats flush, writeback and load; write_en during reset is ignored.
REQ-029 in_ready is 1 in the first cycle after reset deasserts.

Structure
REQ-030 Package decode_pkg holds opcode constants, ALU op constants and the control-bundle struct.
REQ-031 Sub-module reg_file_p (DATA_W parameter, 2 read ports, 1 write port with bypass); decode, hazard and handshake logic stay in the top.

Verification
REQ-032 Reset, write R3=0x1234, then ADD rd=R3, rs2=R3 -> next cycle read_data1_buf=read_data2_buf=0x1234, alu 001, wb_buf=1.
REQ-033 write_en R5=0x00AA in the same cycle as decode of rs1=R5 -> read_data1_buf=0x00AA (bypass).
REQ-034 LD rd=R2, then ADD rs2=R2 back-to-back with out_ready=1 -> in_ready=0 one cycle, one bubble (out_valid=0), ADD output two cycles after LD's.
REQ-035 out_ready=0 for 3 cycles with out_valid=1 -> outputs constant, in_ready=0; release -> next instruction loads 1 cycle later.
REQ-036 LDI imm=0x80: IMM_SIGNED=0 -> immediate_buf=0x0080; IMM_SIGNED=1 -> 0xFF80 (DATA_W=16).
REQ-037 flush asserted with in_valid=1 while stalled -> out_valid=0 next cycle, instruction dropped; reset mid-stall -> all outputs 0, in_ready=1 after release.

Source files
------------

// File: rtl/decode_pkg.sv
// Shared opcode/ALU encodings and the decoded control bundle for the decode stage.
package decode_pkg;

    typedef enum logic [2:0] {
        OP_NOP = 3'b000,
        OP_ADD = 3'b001,
        OP_SUB = 3'b010,
        OP_AND = 3'b011,
        OP_OR  = 3'b100,
        OP_LDI = 3'b101,
        OP_LD  = 3'b110,
        OP_ST  = 3'b111
    } opcode_t;

    localparam logic [2:0] ALU_PASS = 3'b000;
    localparam logic [2:0] ALU_ADD  = 3'b001;

    typedef struct packed {
        logic [2:0] alu_op;
        logic       mem_read;
        logic       mem_write;
        logic       wb;
        logic       dest_sel;
    } ctrl_t;

    function automatic ctrl_t decode_ctrl(input opcode_t op);
        ctrl_t c;
        c = '0;
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR: begin
                c.alu_op = op;
                c.wb     = 1'b1;
            end
            OP_LDI: begin
                c.alu_op   = ALU_PASS;
                c.wb       = 1'b1;
                c.dest_sel = 1'b1;
            end
            // Loads and stores form their address as rs2 + imm in the ALU.
            OP_LD: begin
                c.alu_op   = ALU_ADD;
                c.mem_read = 1'b1;
                c.wb       = 1'b1;
            end
            OP_ST: begin
                c.alu_op    = ALU_ADD;
                c.mem_write = 1'b1;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

    function automatic logic uses_rs1(input opcode_t op);
        return (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) ||
               (op == OP_OR)  || (op == OP_ST);
    endfunction

    function automatic logic uses_rs2(input opcode_t op);
        return (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) ||
               (op == OP_OR)  || (op == OP_LD)  || (op == OP_ST);
    endfunction

endpackage

// File: rtl/reg_file_p.sv
// 8-entry register file, two async read ports, one write port with write-through bypass.
module reg_file_p #(
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [2:0]        i_raddr1,
    input  logic [2:0]        i_raddr2,
    output logic [DATA_W-1:0] o_rdata1,
    output logic [DATA_W-1:0] o_rdata2,
    input  logic              i_we,
    input  logic [2:0]        i_waddr,
    input  logic [DATA_W-1:0] i_wdata
);

    logic [DATA_W-1:0] r_regs [8];
    logic              w_wr;

    assign w_wr = i_we && !reset;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 8; i++) r_regs[i] <= '0;
        end else if (i_we) begin
            r_regs[i_waddr] <= i_wdata;
        end
    end

    // A same-cycle write is visible to readers so decode never sees stale data.
    assign o_rdata1 = (w_wr && (i_waddr == i_raddr1)) ? i_wdata : r_regs[i_raddr1];
    assign o_rdata2 = (w_wr && (i_waddr == i_raddr2)) ? i_wdata : r_regs[i_raddr2];

endmodule

// File: rtl/decode_stage_p.sv
// Decode stage: instruction decode, register read, load-use stall and the ID/EX output register.
module decode_stage_p
    import decode_pkg::*;
#(
    parameter int DATA_W     = 16,
    parameter int IMM_SIGNED = 0,
    parameter int HAZ_EN     = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [15:0]       instruction,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              write_en,
    input  logic [2:0]        write_addr,
    input  logic [DATA_W-1:0] write_data,
    input  logic              flush,
    input  logic              out_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] read_data1_buf,
    output logic [DATA_W-1:0] read_data2_buf,
    output logic [DATA_W-1:0] immediate_buf,
    output logic [2:0]        alu_operation_buf,
    output logic              mem_read_buf,
    output logic              mem_write_buf,
    output logic              wb_buf,
    output logic              destination_alu_select_buf,
    output logic [2:0]        dest_addr_buf
);

    opcode_t                  w_op;
    logic [2:0]               w_rs1;
    logic [2:0]               w_rs2;
    ctrl_t                    w_ctrl;
    logic [DATA_W-1:0]        w_rd1;
    logic [DATA_W-1:0]        w_rd2;
    logic [DATA_W-1:0]        w_imm;
    logic signed [DATA_W-1:0] w_imm_s;
    logic                     w_hazard;
    logic                     w_load;

    logic                     r_out_valid;
    logic [DATA_W-1:0]        r_rd1;
    logic [DATA_W-1:0]        r_rd2;
    logic [DATA_W-1:0]        r_imm;
    ctrl_t                    r_ctrl;
    logic [2:0]               r_dest;

    assign w_op   = opcode_t'(instruction[15:13]);
    assign w_rs1  = instruction[12:10];
    assign w_rs2  = instruction[9:7];
    assign w_ctrl = decode_ctrl(w_op);

    assign w_imm_s = $signed(instruction[7:0]);
    assign w_imm   = (IMM_SIGNED != 0) ? w_imm_s : DATA_W'(instruction[7:0]);

    reg_file_p #(.DATA_W(DATA_W)) u_rf (
        .clk      (clk),
        .reset    (reset),
        .i_raddr1 (w_rs1),
        .i_raddr2 (w_rs2),
        .o_rdata1 (w_rd1),
        .o_rdata2 (w_rd2),
        .i_we     (write_en),
        .i_waddr  (write_addr),
        .i_wdata  (write_data)
    );

    // A load still sitting in ID/EX has no data yet; a consumer of its rd must wait one bubble.
    assign w_hazard = (HAZ_EN != 0) && r_out_valid && r_ctrl.mem_read &&
                      ((uses_rs1(w_op) && (r_dest == w_rs1)) ||
                       (uses_rs2(w_op) && (r_dest == w_rs2)));

    assign in_ready = !flush && !w_hazard && (!r_out_valid || out_ready);
    assign w_load   = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_out_valid <= 1'b0;
            r_rd1       <= '0;
            r_rd2       <= '0;
            r_imm       <= '0;
            r_ctrl      <= '0;
            r_dest      <= '0;
        end else if (flush) begin
            r_out_valid <= 1'b0;
        end else if (w_load) begin
            r_out_valid <= 1'b1;
            r_rd1       <= w_rd1;
            r_rd2       <= w_rd2;
            r_imm       <= w_imm;
            r_ctrl      <= w_ctrl;
            r_dest      <= w_rs1;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign out_valid                  = r_out_valid;
    assign read_data1_buf             = r_rd1;
    assign read_data2_buf             = r_rd2;
    assign immediate_buf              = r_imm;
    assign alu_operation_buf          = r_ctrl.alu_op;
    assign mem_read_buf               = r_ctrl.mem_read;
    assign mem_write_buf              = r_ctrl.mem_write;
    assign wb_buf                     = r_ctrl.wb;
    assign destination_alu_select_buf = r_ctrl.dest_sel;
    assign dest_addr_buf              = r_dest;

endmodule

// File: tb/tb_decode_stage_p.sv
// Bench for decode_stage_p: directed scenarios with literal expectations plus randomized traffic vs a behavioural model.
module tb_decode_stage_p;

    logic        clk = 1'b0;
    logic        reset, in_valid, write_en, flush, out_ready;
    logic [15:0] instruction, write_data;
    logic [2:0]  write_addr;

    logic        in_ready, out_valid, mem_read_buf, mem_write_buf, wb_buf, destination_alu_select_buf;
    logic [15:0] read_data1_buf, read_data2_buf, immediate_buf;
    logic [2:0]  alu_operation_buf, dest_addr_buf;

    logic        s_in_ready, s_out_valid, s_mr, s_mw, s_wb, s_ds;
    logic [15:0] s_rd1, s_rd2, s_imm;
    logic [2:0]  s_alu, s_dst;

    always #5 clk = ~clk;

    decode_stage_p #(.DATA_W(16), .IMM_SIGNED(0), .HAZ_EN(1)) dut (
        .clk(clk), .reset(reset), .instruction(instruction), .in_valid(in_valid), .in_ready(in_ready),
        .write_en(write_en), .write_addr(write_addr), .write_data(write_data), .flush(flush),
        .out_ready(out_ready), .out_valid(out_valid), .read_data1_buf(read_data1_buf),
        .read_data2_buf(read_data2_buf), .immediate_buf(immediate_buf), .alu_operation_buf(alu_operation_buf),
        .mem_read_buf(mem_read_buf), .mem_write_buf(mem_write_buf), .wb_buf(wb_buf),
        .destination_alu_select_buf(destination_alu_select_buf), .dest_addr_buf(dest_addr_buf));

    decode_stage_p #(.DATA_W(16), .IMM_SIGNED(1), .HAZ_EN(1)) dut_s (
        .clk(clk), .reset(reset), .instruction(instruction), .in_valid(in_valid), .in_ready(s_in_ready),
        .write_en(write_en), .write_addr(write_addr), .write_data(write_data), .flush(flush),
        .out_ready(out_ready), .out_valid(s_out_valid), .read_data1_buf(s_rd1),
        .read_data2_buf(s_rd2), .immediate_buf(s_imm), .alu_operation_buf(s_alu),
        .mem_read_buf(s_mr), .mem_write_buf(s_mw), .wb_buf(s_wb),
        .destination_alu_select_buf(s_ds), .dest_addr_buf(s_dst));

    int n_cmp = 0;
    int n_err = 0;
    bit chk_en = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Behavioural model: architectural register array plus the expected output bundle.
    logic [15:0] m_rf [8];
    bit          m_ov = 0;
    logic [15:0] m_rd1 = 0, m_rd2 = 0, m_imm = 0, m_imms = 0;
    logic [2:0]  m_alu = 0, m_dst = 0;
    bit          m_mr = 0, m_mw = 0, m_wb = 0, m_ds = 0;

    function automatic bit reads_rs1(input int op);
        return (op >= 1 && op <= 4) || op == 7;
    endfunction
    function automatic bit reads_rs2(input int op);
        return (op >= 1 && op <= 4) || op == 6 || op == 7;
    endfunction

    function automatic bit m_ready();
        int  op;
        bit  haz;
        op  = int'(instruction[15:13]);
        haz = m_ov && m_mr &&
              ((reads_rs1(op) && m_dst == instruction[12:10]) ||
               (reads_rs2(op) && m_dst == instruction[9:7]));
        return !flush && !haz && (!m_ov || out_ready);
    endfunction

    function automatic logic [15:0] m_read(input logic [2:0] a);
        return (write_en && write_addr == a) ? write_data : m_rf[a];
    endfunction

    always @(posedge clk) begin
        bit ld;
        int op;
        ld = in_valid && m_ready();
        op = int'(instruction[15:13]);
        if (reset) begin
            for (int i = 0; i < 8; i++) m_rf[i] = 0;
            m_ov = 0; m_rd1 = 0; m_rd2 = 0; m_imm = 0; m_imms = 0;
            m_alu = 0; m_dst = 0; m_mr = 0; m_mw = 0; m_wb = 0; m_ds = 0;
        end else begin
            if (flush) m_ov = 0;
            else if (ld) begin
                m_ov   = 1;
                m_rd1  = m_read(instruction[12:10]);
                m_rd2  = m_read(instruction[9:7]);
                m_imm  = {8'h00, instruction[7:0]};
                m_imms = {{8{instruction[7]}}, instruction[7:0]};
                m_dst  = instruction[12:10];
                m_alu  = (op >= 1 && op <= 4) ? 3'(op) : (op >= 6 ? 3'd1 : 3'd0);
                m_wb   = (op >= 1 && op <= 6);
                m_mr   = (op == 6);
                m_mw   = (op == 7);
                m_ds   = (op == 5);
            end else if (out_ready) m_ov = 0;
            if (write_en) m_rf[write_addr] = write_data;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("out_valid", out_valid, m_ov);
            chk("in_ready", in_ready, m_ready());
            chk("rd1", read_data1_buf, m_rd1);
            chk("rd2", read_data2_buf, m_rd2);
            chk("imm", immediate_buf, m_imm);
            chk("alu", alu_operation_buf, m_alu);
            chk("ctrl", {mem_read_buf, mem_write_buf, wb_buf, destination_alu_select_buf},
                {m_mr, m_mw, m_wb, m_ds});
            chk("dest", dest_addr_buf, m_dst);
            chk("imm_signed", s_imm, m_imms);
            chk("s_out_valid", s_out_valid, m_ov);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1; in_valid = 0; write_en = 0; flush = 0; out_ready = 1;
        instruction = 0; write_data = 0; write_addr = 0;
        tick(); tick();
        chk_en = 1;
        reset = 0;
        #1;
        chk("rst out_valid", out_valid, 0);
        chk("rst in_ready", in_ready, 1);
        chk("rst rd1", read_data1_buf, 0);

        // Write R3 then ADD rd=R3, rs2=R3.
        write_en = 1; write_addr = 3; write_data = 16'h1234; tick(); write_en = 0;
        instruction = 16'h2D80; in_valid = 1; tick(); in_valid = 0;
        chk("add rd1", read_data1_buf, 16'h1234);
        chk("add rd2", read_data2_buf, 16'h1234);
        chk("add alu", alu_operation_buf, 3'd1);
        chk("add wb", wb_buf, 1);

        // Bypass: write R5 in the same cycle as decoding rs1=R5.
        write_en = 1; write_addr = 5; write_data = 16'h00AA;
        instruction = 16'h3400; in_valid = 1; tick(); write_en = 0; in_valid = 0;
        chk("bypass rd1", read_data1_buf, 16'h00AA);

        // Load-use: LD rd=R2 then ADD rs2=R2.
        instruction = 16'hC805; in_valid = 1; tick();
        chk("ld mem_read", mem_read_buf, 1);
        instruction = 16'h2500; #1;
        chk("lu in_ready", in_ready, 0);
        tick();
        chk("lu bubble", out_valid, 0);
        chk("lu ready", in_ready, 1);
        tick(); in_valid = 0;
        chk("lu add valid", out_valid, 1);
        chk("lu add alu", alu_operation_buf, 3'd1);

        // Backpressure for 3 cycles.
        instruction = 16'h2D80; in_valid = 1; tick();
        out_ready = 0; instruction = 16'h3400;
        repeat (3) begin
            tick();
            chk("bp valid", out_valid, 1);
            chk("bp rd1", read_data1_buf, 16'h1234);
            chk("bp in_ready", in_ready, 0);
        end
        out_ready = 1; tick(); in_valid = 0;
        chk("bp release rd1", read_data1_buf, 16'h00AA);

        // LDI imm=0x80 under both extension modes.
        instruction = 16'hA080; in_valid = 1; tick(); in_valid = 0;
        chk("ldi imm zext", immediate_buf, 16'h0080);
        chk("ldi imm sext", s_imm, 16'hFF80);
        chk("ldi dsel", destination_alu_select_buf, 1);

        // Flush while stalled.
        instruction = 16'hC805; in_valid = 1; tick();
        out_ready = 0; instruction = 16'h2500; tick();
        chk("stall in_ready", in_ready, 0);
        flush = 1; #1;
        chk("flush in_ready", in_ready, 0);
        tick(); flush = 0; in_valid = 0;
        chk("flush valid", out_valid, 0);

        // Reset in the middle of a stall.
        out_ready = 1; instruction = 16'hC805; in_valid = 1; tick();
        out_ready = 0; instruction = 16'h2500; tick();
        reset = 1; tick(); reset = 0; in_valid = 0; #1;
        chk("rst2 valid", out_valid, 0);
        chk("rst2 mem_read", mem_read_buf, 0);
        chk("rst2 imm", immediate_buf, 0);
        chk("rst2 in_ready", in_ready, 1);
        out_ready = 1; instruction = 16'h2D80; in_valid = 1; tick(); in_valid = 0;
        chk("rst2 rf cleared", read_data1_buf, 0);

        // Randomized traffic.
        for (int c = 0; c < 4000; c++) begin
            reset       = ($urandom_range(0, 199) == 0);
            in_valid    = ($urandom_range(0, 9) < 7);
            instruction = 16'($urandom);
            write_en    = $urandom_range(0, 1);
            write_addr  = 3'($urandom);
            write_data  = 16'($urandom);
            flush       = ($urandom_range(0, 19) == 0);
            out_ready   = ($urandom_range(0, 9) < 7);
            tick();
        end
        reset = 0; in_valid = 0; write_en = 0; flush = 0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
